// File: rtl/ring_microcode_sequencer.sv
// One-hot T-state ring sequencer for the 8-bit bus machine: decodes the fetch/execute
// control word from (ring, opcode, flags), latches C/Z after ADD/SUB, and handles halt.
module ring_microcode_sequencer #(
  parameter int N_TSTATES = 6,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [3:0]           op_code,
  input  logic                 carry_flag,
  input  logic                 zero_flag,
  output logic                 inc,
  output logic                 pc_out_en,
  output logic                 ld_pc,
  output logic                 low_ld_mar,
  output logic                 low_mem_out_en,
  output logic                 low_ld_ir,
  output logic                 low_ir_out_en,
  output logic                 low_ld_acc,
  output logic                 acc_out_en,
  output logic                 sub_add,
  output logic                 subadd_out_en,
  output logic                 low_ld_b_reg,
  output logic                 low_ld_out_reg,
  output logic                 low_halt,
  output logic [N_TSTATES-1:0] t_state,
  output logic [1:0]           flags
);

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_JMP = 4'b0111,
    OP_JC  = 4'b1000,
    OP_JZ  = 4'b1001,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Control word held active-high internally; polarity is applied only at the ports.
  typedef struct packed {
    logic inc;
    logic pc_out;
    logic ld_pc;
    logic ld_mar;
    logic mem_out;
    logic ld_ir;
    logic ir_out;
    logic ld_acc;
    logic acc_out;
    logic sub_add;
    logic alu_out;
    logic ld_b;
    logic ld_out;
  } ctrl_t;

  localparam logic [N_TSTATES-1:0] T1 = {{(N_TSTATES-1){1'b0}}, 1'b1};
  localparam logic [N_TSTATES-1:0] T2 = T1 << 1;
  localparam logic [N_TSTATES-1:0] T3 = T1 << 2;
  localparam logic [N_TSTATES-1:0] T4 = T1 << 3;
  localparam logic [N_TSTATES-1:0] T5 = T1 << 4;
  localparam logic [N_TSTATES-1:0] T6 = T1 << 5;

  logic [N_TSTATES-1:0] t_state_q, t_state_d;
  logic [1:0]           flags_q, flags_d;
  logic                 halted_q, halted_d;
  logic                 ring_legal;
  logic                 last_step;
  logic                 is_alu_op;
  ctrl_t                ctrl;

  assign ring_legal = $onehot(t_state_q);
  assign is_alu_op  = (op_code == OP_ADD) || (op_code == OP_SUB);

  // Final T-state of the current instruction; HLT never ends, it freezes at T5.
  always_comb begin
    last_step = t_state_q[N_TSTATES-1];
    if (EARLY_END) begin
      case (op_code)
        OP_LDA:                       last_step = t_state_q[4];
        OP_ADD, OP_SUB:               last_step = t_state_q[5];
        OP_JMP, OP_JC, OP_JZ, OP_OUT: last_step = t_state_q[3];
        OP_HLT:                       last_step = 1'b0;
        default:                      last_step = t_state_q[2];
      endcase
    end
  end

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    t_state_d = t_state_q;
    flags_d   = flags_q;
    halted_d  = halted_q;
    if (!ring_legal) begin
      t_state_d = T1;
    end else if (!halted_q) begin
      if ((op_code == OP_HLT) && (t_state_q == T4)) begin
        halted_d  = 1'b1;
        t_state_d = T5;
      end else if (last_step) begin
        t_state_d = T1;
      end else begin
        t_state_d = t_state_q << 1;
      end
      if ((t_state_q == T6) && is_alu_op) flags_d = {carry_flag, zero_flag};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_state_q <= T1;
      flags_q   <= 2'b00;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      flags_q   <= flags_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    ctrl = '0;
    if (!clr && !halted_q) begin
      case (t_state_q)
        T1: begin
          ctrl.pc_out = 1'b1;
          ctrl.ld_mar = 1'b1;
        end
        T2: ctrl.inc = 1'b1;
        T3: begin
          ctrl.mem_out = 1'b1;
          ctrl.ld_ir   = 1'b1;
        end
        T4: begin
          case (op_code)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ir_out = 1'b1;
              ctrl.ld_mar = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out = 1'b1;
              ctrl.ld_pc  = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out = flags_q[1];
              ctrl.ld_pc  = flags_q[1];
            end
            OP_JZ: begin
              ctrl.ir_out = flags_q[0];
              ctrl.ld_pc  = flags_q[0];
            end
            OP_OUT: begin
              ctrl.acc_out = 1'b1;
              ctrl.ld_out  = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          if (op_code == OP_LDA) begin
            ctrl.mem_out = 1'b1;
            ctrl.ld_acc  = 1'b1;
          end else if (is_alu_op) begin
            ctrl.mem_out = 1'b1;
            ctrl.ld_b    = 1'b1;
            ctrl.sub_add = (op_code == OP_SUB);
          end
        end
        T6: begin
          if (is_alu_op) begin
            ctrl.alu_out = 1'b1;
            ctrl.ld_acc  = 1'b1;
            ctrl.sub_add = (op_code == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign inc            = ctrl.inc;
  assign pc_out_en      = ctrl.pc_out;
  assign ld_pc          = ctrl.ld_pc;
  assign low_ld_mar     = ~ctrl.ld_mar;
  assign low_mem_out_en = ~ctrl.mem_out;
  assign low_ld_ir      = ~ctrl.ld_ir;
  assign low_ir_out_en  = ~ctrl.ir_out;
  assign low_ld_acc     = ~ctrl.ld_acc;
  assign acc_out_en     = ctrl.acc_out;
  assign sub_add        = ctrl.sub_add;
  assign subadd_out_en  = ctrl.alu_out;
  assign low_ld_b_reg   = ~ctrl.ld_b;
  assign low_ld_out_reg = ~ctrl.ld_out;
  assign low_halt       = clr | ~halted_q;
  assign t_state        = t_state_q;
  assign flags          = flags_q;

endmodule

// File: tb/tb_ring_microcode_sequencer.sv
// Bench for ring_microcode_sequencer: one early-end and one full-ring instance, each
// tracked by a step-count reference model; directed instruction table plus random traffic.
module tb_ring_microcode_sequencer;

  // Observation vector bit positions.
  localparam int S_INC = 13, S_PC_OUT = 12, S_LD_PC = 11, S_LD_MAR = 10, S_MEM_OUT = 9;
  localparam int S_LD_IR = 8, S_IR_OUT = 7, S_LD_ACC = 6, S_ACC_OUT = 5, S_SUB = 4;
  localparam int S_ALU_OUT = 3, S_LD_B = 2, S_LD_OUT = 1, S_HALT = 0;
  localparam logic [13:0] ACT_LOW = 14'b00011111000111;

  logic       clk = 1'b0;
  logic       clr;
  logic       carry, zero;
  logic [3:0] op [2];

  wire [13:0] ctrl0, ctrl1;
  wire [5:0]  ts0, ts1;
  wire [1:0]  fl0, fl1;

  int n_checks = 0;
  int n_pass   = 0;

  int         mstep  [2];
  bit         mhalt  [2];
  logic [1:0] mflags [2];
  bit         auto_op [2];
  bit         ldpc_seen [2];
  bit         rand_flags;

  always #5 clk = ~clk;

  ring_microcode_sequencer #(.N_TSTATES(6), .EARLY_END(1'b1)) dut (
    .clk(clk), .clr(clr), .op_code(op[0]), .carry_flag(carry), .zero_flag(zero),
    .inc(ctrl0[S_INC]), .pc_out_en(ctrl0[S_PC_OUT]), .ld_pc(ctrl0[S_LD_PC]),
    .low_ld_mar(ctrl0[S_LD_MAR]), .low_mem_out_en(ctrl0[S_MEM_OUT]),
    .low_ld_ir(ctrl0[S_LD_IR]), .low_ir_out_en(ctrl0[S_IR_OUT]),
    .low_ld_acc(ctrl0[S_LD_ACC]), .acc_out_en(ctrl0[S_ACC_OUT]), .sub_add(ctrl0[S_SUB]),
    .subadd_out_en(ctrl0[S_ALU_OUT]), .low_ld_b_reg(ctrl0[S_LD_B]),
    .low_ld_out_reg(ctrl0[S_LD_OUT]), .low_halt(ctrl0[S_HALT]),
    .t_state(ts0), .flags(fl0)
  );

  ring_microcode_sequencer #(.N_TSTATES(6), .EARLY_END(1'b0)) dut_full (
    .clk(clk), .clr(clr), .op_code(op[1]), .carry_flag(carry), .zero_flag(zero),
    .inc(ctrl1[S_INC]), .pc_out_en(ctrl1[S_PC_OUT]), .ld_pc(ctrl1[S_LD_PC]),
    .low_ld_mar(ctrl1[S_LD_MAR]), .low_mem_out_en(ctrl1[S_MEM_OUT]),
    .low_ld_ir(ctrl1[S_LD_IR]), .low_ir_out_en(ctrl1[S_IR_OUT]),
    .low_ld_acc(ctrl1[S_LD_ACC]), .acc_out_en(ctrl1[S_ACC_OUT]), .sub_add(ctrl1[S_SUB]),
    .subadd_out_en(ctrl1[S_ALU_OUT]), .low_ld_b_reg(ctrl1[S_LD_B]),
    .low_ld_out_reg(ctrl1[S_LD_OUT]), .low_halt(ctrl1[S_HALT]),
    .t_state(ts1), .flags(fl1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [13:0] ctrl_of(int d);
    return (d == 0) ? ctrl0 : ctrl1;
  endfunction

  function automatic logic [5:0] ts_of(int d);
    return (d == 0) ? ts0 : ts1;
  endfunction

  function automatic logic [1:0] fl_of(int d);
    return (d == 0) ? fl0 : fl1;
  endfunction

  // Number of T-states an instruction occupies before the ring returns to T1.
  function automatic int instr_len(logic [3:0] o, bit early);
    if (!early) return 6;
    case (o)
      4'b0000:                            return 5;
      4'b0001, 4'b0010:                   return 6;
      4'b0111, 4'b1000, 4'b1001, 4'b1110: return 4;
      4'b1111:                            return 99;
      default:                            return 3;
    endcase
  endfunction

  function automatic logic [13:0] exp_ctrl(int step, logic [3:0] o, logic [1:0] fl,
                                           bit halted, bit clr_in);
    logic [13:0] act;
    act = '0;
    if (clr_in) return ACT_LOW;
    if (halted) begin
      act[S_HALT] = 1'b1;
      return act ^ ACT_LOW;
    end
    case (step)
      1: begin act[S_PC_OUT] = 1'b1; act[S_LD_MAR] = 1'b1; end
      2: act[S_INC] = 1'b1;
      3: begin act[S_MEM_OUT] = 1'b1; act[S_LD_IR] = 1'b1; end
      4: begin
        if (o == 4'b0000 || o == 4'b0001 || o == 4'b0010) begin
          act[S_IR_OUT] = 1'b1; act[S_LD_MAR] = 1'b1;
        end
        if (o == 4'b0111 || (o == 4'b1000 && fl[1]) || (o == 4'b1001 && fl[0])) begin
          act[S_IR_OUT] = 1'b1; act[S_LD_PC] = 1'b1;
        end
        if (o == 4'b1110) begin act[S_ACC_OUT] = 1'b1; act[S_LD_OUT] = 1'b1; end
      end
      5: begin
        if (o == 4'b0000) begin act[S_MEM_OUT] = 1'b1; act[S_LD_ACC] = 1'b1; end
        if (o == 4'b0001 || o == 4'b0010) begin
          act[S_MEM_OUT] = 1'b1; act[S_LD_B] = 1'b1; act[S_SUB] = (o == 4'b0010);
        end
      end
      6: begin
        if (o == 4'b0001 || o == 4'b0010) begin
          act[S_ALU_OUT] = 1'b1; act[S_LD_ACC] = 1'b1; act[S_SUB] = (o == 4'b0010);
        end
      end
      default: ;
    endcase
    return act ^ ACT_LOW;
  endfunction

  task automatic model_tick(int d, bit early);
    if (clr) begin
      mstep[d] = 1; mhalt[d] = 1'b0; mflags[d] = 2'b00;
    end else if (!mhalt[d]) begin
      if (op[d] == 4'hF && mstep[d] == 4) begin
        mstep[d] = 5; mhalt[d] = 1'b1;
      end else begin
        if (mstep[d] == 6 && (op[d] == 4'h1 || op[d] == 4'h2)) mflags[d] = {carry, zero};
        mstep[d] = (mstep[d] >= instr_len(op[d], early)) ? 1 : mstep[d] + 1;
      end
    end
  endtask

  // Entered and left at a falling edge with inputs already applied.
  task automatic step_cycle();
    logic [13:0] c;
    logic [5:0]  et;
    #1;
    for (int d = 0; d < 2; d++) begin
      c  = ctrl_of(d);
      et = 6'b000001 << (mstep[d] - 1);
      check($sformatf("dut%0d ctrl T%0d op%h", d, mstep[d], op[d]), c,
            exp_ctrl(mstep[d], op[d], mflags[d], mhalt[d], clr));
      check($sformatf("dut%0d t_state", d), ts_of(d), et);
      check($sformatf("dut%0d flags", d), fl_of(d), mflags[d]);
      if (c[S_LD_PC]) ldpc_seen[d] = 1'b1;
    end
    @(posedge clk);
    model_tick(0, 1'b1);
    model_tick(1, 1'b0);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      if (auto_op[d] && mstep[d] == 1 && !mhalt[d]) op[d] = 4'($urandom_range(0, 15));
    if (rand_flags) begin
      carry = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_instr(input int d, input logic [3:0] o, input logic c, input logic z,
                           output int cycles);
    op[d] = o; carry = c; zero = z;
    ldpc_seen[d] = 1'b0;
    cycles = 0;
    do begin
      step_cycle();
      cycles++;
    end while (ts_of(d) != 6'b000001 && cycles < 12);
  endtask

  typedef struct {
    logic [3:0] op;
    logic       c;
    logic       z;
    int         len;
    bit         ldpc;
    logic [1:0] fl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int cyc;
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 5, 1'b0, 2'b00};  // LDA
    tbl[1]  = '{4'h1, 1'b1, 1'b0, 6, 1'b0, 2'b10};  // ADD sets C
    tbl[2]  = '{4'h8, 1'b0, 1'b0, 4, 1'b1, 2'b10};  // JC taken
    tbl[3]  = '{4'h9, 1'b0, 1'b0, 4, 1'b0, 2'b10};  // JZ not taken
    tbl[4]  = '{4'h2, 1'b0, 1'b1, 6, 1'b0, 2'b01};  // SUB sets Z
    tbl[5]  = '{4'h9, 1'b0, 1'b0, 4, 1'b1, 2'b01};  // JZ taken
    tbl[6]  = '{4'h8, 1'b1, 1'b1, 4, 1'b0, 2'b01};  // JC ignores live carry
    tbl[7]  = '{4'hE, 1'b0, 1'b0, 4, 1'b0, 2'b01};  // OUT
    tbl[8]  = '{4'h4, 1'b0, 1'b0, 3, 1'b0, 2'b01};  // NOP
    tbl[9]  = '{4'h7, 1'b0, 1'b0, 4, 1'b1, 2'b01};  // JMP
    tbl[10] = '{4'h1, 1'b1, 1'b1, 6, 1'b0, 2'b11};  // ADD sets C and Z
    tbl[11] = '{4'h9, 1'b0, 1'b0, 4, 1'b1, 2'b11};  // JZ taken

    for (int d = 0; d < 2; d++) begin
      mstep[d] = 1; mhalt[d] = 1'b0; mflags[d] = 2'b00; ldpc_seen[d] = 1'b0;
      op[d] = 4'h0;
    end
    auto_op[0] = 1'b0; auto_op[1] = 1'b1;
    rand_flags = 1'b0;
    clr = 1'b1; carry = 1'b0; zero = 1'b0;

    // Two reset edges; the second is checked with clr still asserted.
    @(posedge clk);
    @(negedge clk);
    step_cycle();
    clr = 1'b0;

    foreach (tbl[i]) begin
      run_instr(0, tbl[i].op, tbl[i].c, tbl[i].z, cyc);
      check($sformatf("vec%0d length", i), cyc, tbl[i].len);
      check($sformatf("vec%0d ld_pc seen", i), ldpc_seen[0], tbl[i].ldpc);
      check($sformatf("vec%0d flags", i), fl0, tbl[i].fl);
    end

    // HLT freezes the ring at T5 until clr.
    op[0] = 4'hF;
    repeat (4) step_cycle();
    for (int i = 0; i < 20; i++) begin
      check("halt t_state", ts0, 6'b010000);
      check("halt low_halt", ctrl0[S_HALT], 1'b0);
      step_cycle();
    end
    clr = 1'b1;
    step_cycle();
    clr = 1'b0;
    check("post-halt t_state", ts0, 6'b000001);
    check("post-halt low_halt", ctrl0[S_HALT], 1'b1);
    check("full ring t_state after clr", ts1, 6'b000001);

    // Full-ring instance: every instruction takes six states.
    auto_op[0] = 1'b1; auto_op[1] = 1'b0;
    run_instr(1, 4'hE, 1'b0, 1'b0, cyc);
    check("full OUT length", cyc, 6);
    run_instr(1, 4'h0, 1'b0, 1'b0, cyc);
    check("full LDA length", cyc, 6);
    run_instr(1, 4'h4, 1'b0, 1'b0, cyc);
    check("full NOP length", cyc, 6);
    run_instr(1, 4'h8, 1'b1, 1'b0, cyc);
    check("full JC length", cyc, 6);

    clr = 1'b1;
    step_cycle();
    clr = 1'b0;
    auto_op[0] = 1'b0;
    run_instr(0, 4'h4, 1'b0, 1'b0, cyc);
    check("early NOP length", cyc, 3);

    // Random traffic with occasional clr, checked cycle by cycle against the model.
    auto_op[0] = 1'b1; auto_op[1] = 1'b1;
    rand_flags = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      step_cycle();
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
